// File: rtl/dct_quant_zigzag.sv
// 8x8 DCT coefficient quantizer with zigzag reordering.
// Accepts 8 rows of coefficients, then streams 64 quantized values in JPEG zigzag order.
module dct_quant_zigzag #(
    parameter int IN_W  = 32,
    parameter int FRAC  = 14,
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [8*IN_W-1:0]       in_row,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_coef,
    output logic [5:0]              out_idx,
    output logic                    out_last,
    input  logic                    out_ready
);

    typedef enum logic {LOAD, EMIT} state_t;

    localparam int PW  = IN_W + 18;
    localparam int LIM = 2 ** (OUT_W - 1);
    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    localparam int Q_TAB [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Reciprocals round(65536/Q) with half-up rounding, folded to constants at elaboration.
    logic [15:0] r_tab [64];
    for (genvar k = 0; k < 64; k++) begin : g_recip
        assign r_tab[k] = 16'((131072 + Q_TAB[k]) / (2 * Q_TAB[k]));
    end

    function automatic logic signed [OUT_W-1:0] quantize(
        input logic signed [IN_W-1:0] x,
        input logic [15:0]            r
    );
        logic signed [PW-1:0] p;
        logic [PW-1:0]        m;
        logic [PW-1:0]        q;
        p = PW'(x) * $signed(PW'(r));
        m = p[PW-1] ? -p : p;
        q = (m + (PW'(1) << (FRAC + 15))) >> (FRAC + 16);
        if (!x[IN_W-1])
            return (q > PW'(LIM - 1)) ? SAT_MAX : OUT_W'(q);
        else
            return (q > PW'(LIM)) ? SAT_MIN : OUT_W'(-q);
    endfunction

    state_t                  state;
    logic [2:0]              row_cnt;
    logic                    accept;
    logic signed [OUT_W-1:0] q_row [8];
    logic signed [OUT_W-1:0] coef_buf [64];

    assign accept = in_valid && in_ready;

    always_comb begin
        for (int lane = 0; lane < 8; lane++)
            q_row[lane] = quantize(in_row[lane*IN_W +: IN_W], r_tab[{row_cnt, 3'(lane)}]);
    end

    // NOTE: the coefficient buffer has no reset; a block always fully rewrites it before emission.
    always_ff @(posedge clk) begin
        if (accept)
            for (int lane = 0; lane < 8; lane++)
                coef_buf[{row_cnt, 3'(lane)}] <= q_row[lane];
        if (accept && row_cnt == 3'd7)
            out_coef <= coef_buf[0];
        else if (state == EMIT && out_ready && out_idx != 6'd63)
            out_coef <= coef_buf[ZZ[out_idx + 6'd1]];
    end

    // NOTE: all state and registered outputs use non-blocking assignment so they update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            row_cnt   <= 3'd0;
            out_idx   <= 6'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_idx   <= 6'd0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_idx == 6'd63) begin
                            state     <= LOAD;
                            row_cnt   <= 3'd0;
                            out_idx   <= 6'd0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_idx  <= out_idx + 6'd1;
                            out_last <= (out_idx == 6'd62);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Scoreboard bench for dct_quant_zigzag: directed corner blocks, random back-pressure, mid-emit reset.
module tb_dct_quant_zigzag;

    localparam int IN_W  = 32;
    localparam int FRAC  = 14;
    localparam int OUT_W = 12;
    localparam int BUDGET = 3000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [8*IN_W-1:0]       in_row;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_coef;
    logic [5:0]              out_idx;
    logic                    out_last;
    logic                    out_ready;

    dct_quant_zigzag #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_ready(in_ready),
        .out_valid(out_valid), .out_coef(out_coef), .out_idx(out_idx), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int coef;
        int idx;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    blk [64];
    int    dir_exp [64];
    int    zz [64];
    int    q_tab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    function automatic int model(input int x, input int k);
        longint r, p, m, q, res;
        r = longint'($rtoi(65536.0 / q_tab[k] + 0.5));
        p = longint'(x) * r;
        m = (p < 0) ? -p : p;
        q = (m + (longint'(1) << (FRAC + 15))) >>> (FRAC + 16);
        res = (x < 0) ? -q : q;
        if (res > 2047) res = 2047;
        if (res < -2048) res = -2048;
        return int'(res);
    endfunction

    task automatic build_zigzag();
        int pos = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0)
                for (int r = hi; r >= lo; r--) begin zz[pos] = r * 8 + (s - r); pos++; end
            else
                for (int r = lo; r <= hi; r++) begin zz[pos] = r * 8 + (s - r); pos++; end
        end
    endtask

    task automatic clear_block();
        for (int i = 0; i < 64; i++) begin blk[i] = 0; dir_exp[i] = 0; end
    endtask

    task automatic load_block(input bit use_model, input int gap_pct);
        int row = 0;
        int cyc = 0;
        for (int i = 0; i < 64; i++)
            exp_q.push_back('{use_model ? model(blk[zz[i]], zz[i]) : dir_exp[i], i});
        while (row < 8 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_row   = {8{$urandom}};
            end else begin
                in_valid = 1'b1;
                for (int c = 0; c < 8; c++) in_row[c*IN_W +: IN_W] = blk[row*8 + c];
            end
            if (in_valid && in_ready) row++;
        end
        if (row < 8) begin
            checks++; errors++;
            $display("FAIL load_timeout: rows accepted %0d, required 8", row);
        end
    endtask

    task automatic emit_block(input int stall_pct, input int stop_idx);
        bit    first = 1'b1;
        bit    done  = 1'b0;
        int    cyc   = 0;
        beat_t e;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: out_valid=%b the cycle after row 7, required 1", out_valid);
                end
                first = 1'b0;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_emit: in_ready=%b during EMIT, required 0", in_ready);
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: idx %0d coef %0d with empty scoreboard", out_idx, out_coef);
                    done = 1'b1;
                end else begin
                    e = exp_q[0];
                    checks++;
                    if (int'(out_idx) !== e.idx || int'(out_coef) !== e.coef || out_last !== (e.idx == 63)) begin
                        errors++;
                        $display("FAIL beat: got idx=%0d coef=%0d last=%b, required idx=%0d coef=%0d last=%b",
                                 out_idx, out_coef, out_last, e.idx, e.coef, e.idx == 63);
                    end
                    if (e.idx == stop_idx) begin
                        out_ready = 1'b0;
                        in_valid  = 1'b0;
                        done      = 1'b1;
                    end else begin
                        out_ready = (int'($urandom_range(99)) >= stall_pct);
                        in_valid  = $urandom_range(1);
                        in_row    = {8{$urandom}};
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            if (e.idx == 63) begin
                                in_valid = 1'b0;
                                done     = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL emit_timeout: %0d beats outstanding", exp_q.size());
        end else if (stop_idx > 63) begin
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0) begin
                errors++;
                $display("FAIL return_load: out_valid=%b in_ready=%b out_idx=%0d, required 0 1 0",
                         out_valid, in_ready, out_idx);
            end
        end
    endtask

    task automatic run_block(input bit use_model, input int gap_pct, input int stall_pct);
        load_block(use_model, gap_pct);
        emit_block(stall_pct, 64);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_last=%b out_idx=%0d, required 1 0 0 0",
                     in_ready, out_valid, out_last, out_idx);
        end
    endtask

    task automatic test_dc();
        clear_block();
        blk[0] = 16777216; dir_exp[0] = 64;
        run_block(1'b0, 0, 0);
    endtask

    task automatic test_zigzag();
        clear_block();
        blk[1] = 11 * 16384; blk[8] = 24 * 16384;
        dir_exp[1] = 1; dir_exp[2] = 2;
        run_block(1'b0, 20, 20);
    endtask

    task automatic test_rounding();
        clear_block(); blk[0] = -131072; dir_exp[0] = -1; run_block(1'b0, 0, 0);
        clear_block(); blk[0] = 131072;  dir_exp[0] = 1;  run_block(1'b0, 0, 0);
        clear_block(); blk[0] = 126976;  dir_exp[0] = 0;  run_block(1'b0, 0, 0);
    endtask

    task automatic test_saturation();
        clear_block(); blk[0] = 1073741824;  dir_exp[0] = 2047;  run_block(1'b0, 0, 0);
        clear_block(); blk[0] = -1073741824; dir_exp[0] = -2048; run_block(1'b0, 0, 0);
    endtask

    task automatic random_fill();
        for (int i = 0; i < 64; i++)
            blk[i] = int'($urandom) >>> $urandom_range(14, 3);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            random_fill();
            run_block(1'b1, 30, 40);
        end
    endtask

    task automatic test_reset_mid_emit();
        random_fill();
        load_block(1'b1, 10);
        emit_block(30, 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_emit: out_valid=%b in_ready=%b out_idx=%0d out_last=%b, required 0 1 0 0",
                     out_valid, in_ready, out_idx, out_last);
        end
        exp_q.delete();
        random_fill();
        run_block(1'b1, 10, 30);
    endtask

    initial begin
        build_zigzag();
        test_reset();
        test_dc();
        test_zigzag();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
